// File: rtl/keypad_scan_if.sv
// Key handshake bundle between keypad_scan (master) and the key consumer (slave).
interface keypad_scan_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_down;
  logic       overrun;

  modport master (output key_code, key_valid, key_down, overrun, input key_ack);
  modport slave  (input key_code, key_valid, key_down, overrun, output key_ack);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame-based debounce and a valid/ack key handshake.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned DEB_FRAMES   = 8,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic         clk,
  input  logic         rst,
  output logic [3:0]   row,
  input  logic [3:0]   col,
  keypad_scan_if.master kif
);

  localparam int unsigned SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0]  DEB = 4'(DEB_FRAMES);

  if (DEB_FRAMES < 1 || DEB_FRAMES > 15 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("keypad_scan: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

  logic [3:0]    col_s1, col_s2;
  logic [SW-1:0] slot;
  logic [1:0]    row_idx;
  logic          slot_end, frame_end;

  assign slot_end  = (slot == SW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (row_idx == 2'd3);
  assign row       = ~(4'b0001 << row_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1  <= '1;
      col_s2  <= '1;
      slot    <= '0;
      row_idx <= '0;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
      if (slot_end) begin
        slot    <= '0;
        row_idx <= row_idx + 2'd1;
      end else begin
        slot <= slot + SW'(1);
      end
    end
  end

  // Frame hit count saturates at 2 (MULTI); a row-0 slot starts a fresh frame.
  logic [1:0] slot_n, hit_col, acc_n, base_n, tot;
  logic [3:0] acc_code, tot_code;
  logic [2:0] sum;

  always_comb begin
    slot_n  = '0;
    hit_col = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (!col_s2[c]) begin
        hit_col = 2'(c);
        if (slot_n != 2'd2) slot_n = slot_n + 2'd1;
      end
    end
    base_n   = (row_idx == 2'd0) ? 2'd0 : acc_n;
    sum      = {1'b0, base_n} + {1'b0, slot_n};
    tot      = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    tot_code = (base_n == 2'd0) ? {row_idx, hit_col} : acc_code;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_n    <= '0;
      acc_code <= '0;
    end else if (slot_end) begin
      acc_n    <= tot;
      acc_code <= tot_code;
    end
  end

  logic res_none, res_single;
  assign res_none   = (tot == 2'd0);
  assign res_single = (tot == 2'd1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx, cand, cand_nx, accept_code;
  logic       accept;
`ifdef KEYPAD_REPEAT_EN
  logic [15:0] rep, rep_nx;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep   <= '0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cand  <= cand_nx;
`ifdef KEYPAD_REPEAT_EN
      rep   <= rep_nx;
`endif
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    cand_nx     = cand;
    accept      = 1'b0;
    accept_code = cand;
`ifdef KEYPAD_REPEAT_EN
    rep_nx      = rep;
`endif
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (res_single) begin
            cand_nx     = tot_code;
            accept_code = tot_code;
            cnt_nx      = 4'd1;
            if (DEB == 4'd1) begin
              accept   = 1'b1;
              state_nx = HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_nx   = 16'(REPEAT_DELAY);
`endif
            end else begin
              state_nx = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (res_single && tot_code == cand) begin
            cnt_nx = cnt + 4'd1;
            if (cnt + 4'd1 == DEB) begin
              accept   = 1'b1;
              state_nx = HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_nx   = 16'(REPEAT_DELAY);
`endif
            end
          end else begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end
        end
        HELD: begin
          if (res_none) begin
            cnt_nx   = 4'd1;
            state_nx = (DEB == 4'd1) ? IDLE : DEB_REL;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (res_single && tot_code == cand) begin
            if (rep <= 16'd1) begin
              accept = 1'b1;
              rep_nx = 16'(REPEAT_RATE);
            end else begin
              rep_nx = rep - 16'd1;
            end
          end
`endif
        end
        DEB_REL: begin
          if (res_none) begin
            cnt_nx = cnt + 4'd1;
            if (cnt + 4'd1 == DEB) begin
              cnt_nx   = '0;
              state_nx = IDLE;
            end
          end else begin
            state_nx = HELD;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  logic [3:0] code_q;
  logic       valid_q, ovr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (accept) begin
      if (!valid_q) begin
        code_q  <= accept_code;
        valid_q <= 1'b1;
      end else if (kif.key_ack) begin
        code_q  <= accept_code;
        ovr_q   <= 1'b0;
      end else begin
        ovr_q   <= 1'b1;
      end
    end else if (kif.key_ack && valid_q) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign kif.key_code  = code_q;
  assign kif.key_valid = valid_q;
  assign kif.overrun   = ovr_q;
  assign kif.key_down  = (state == HELD) || (state == DEB_REL);

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized bench for keypad_scan: a frame-level keypad/handshake model is checked every cycle.
module tb_keypad_scan;
  localparam int DEB = 3;
  localparam int RD  = 4;
  localparam int RR  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row, col;
  logic [15:0] keys = '0;
  int          checks = 0;
  int          errors = 0;

  keypad_scan_if kif ();

  keypad_scan #(.SCAN_DIV(4), .DEB_FRAMES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .kif(kif)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = '1;
    for (int r = 0; r < 4; r++)
      if (!row[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4 + c]) col[c] = 1'b0;
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: frame results come straight from the pressed-key set.
  int       n = 0, streak = 0, rel = 0, since = 0;
  bit       down = 0, valid = 0, ovr = 0;
  bit [3:0] cand = 0, code = 0, exp_row = 4'b1110;

  always @(posedge clk) begin
    int  pc, idx;
    bit  acc;
    if (!rst) begin
      n = 0; streak = 0; rel = 0; since = 0;
      down = 0; valid = 0; ovr = 0; cand = 0; code = 0;
    end else begin
      acc = 0;
      n++;
      if (n % 16 == 0) begin
        pc  = $countones(keys);
        idx = 0;
        for (int i = 15; i >= 0; i--) if (keys[i]) idx = i;
        if (!down) begin
          if (pc == 1 && streak > 0 && idx == int'(cand)) streak++;
          else if (pc == 1 && streak == 0) begin cand = 4'(idx); streak = 1; end
          else streak = 0;
          if (streak == DEB) begin acc = 1; down = 1; streak = 0; rel = 0; since = 0; end
        end else if (pc == 0) begin
          rel++;
          if (rel == DEB) begin down = 0; rel = 0; end
        end else begin
`ifdef KEYPAD_REPEAT_EN
          if (rel == 0 && pc == 1 && idx == int'(cand)) begin
            since++;
            if (since == RD || (since > RD && (since - RD) % RR == 0)) acc = 1;
          end
`endif
          rel = 0;
        end
      end
      if (acc) begin
        if (!valid) begin code = cand; valid = 1; end
        else if (kif.key_ack) begin code = cand; ovr = 0; end
        else ovr = 1;
      end else if (kif.key_ack && valid) begin
        valid = 0; ovr = 0;
      end
    end
    exp_row = ~(4'b0001 << ((n / 4) % 4));
  end

  always @(posedge clk) begin
    #3;
    check("row", row, exp_row);
    check("key_valid", kif.key_valid, valid);
    check("key_code", kif.key_code, code);
    check("key_down", kif.key_down, down);
    check("overrun", kif.overrun, ovr);
  end

  // Stays frame-aligned when entered just after a frame-end edge.
  task automatic frames(input int k, input bit ack_first, input bit rnd);
    kif.key_ack = ack_first;
    for (int i = 0; i < 16 * k; i++) begin
      @(negedge clk);
      kif.key_ack = rnd ? ($urandom_range(0, 5) == 0) : 1'b0;
    end
  endtask

  initial begin
    logic [3:0] steps [4];
    int         sel, a, b;
    steps = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    kif.key_ack = 1'b0;
    keys = 16'(1) << 9;
    repeat (3) @(negedge clk);
    check("reset_row", row, 4'b1110);
    check("reset_valid", kif.key_valid, 0);
    check("reset_down", kif.key_down, 0);
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i % 4 == 0) check("row_step", row, steps[i/4 - 1]);
    end
    frames(1, 0, 0);
    repeat (15) @(negedge clk);
    check("k9_before", kif.key_valid, 0);
    @(negedge clk);
    check("k9_valid", kif.key_valid, 1);
    check("k9_code", kif.key_code, 9);
    check("k9_down", kif.key_down, 1);
    kif.key_ack = 1'b1;
    @(negedge clk);
    kif.key_ack = 1'b0;
    check("k9_ack", kif.key_valid, 0);
    repeat (15) @(negedge clk);
    frames(2, 0, 0);
    keys = '0; frames(4, 0, 0);

    for (int i = 0; i < 4; i++) begin
      keys = 16'(1) << 6; frames(2, 0, 0);
      keys = '0;          frames(1, 0, 0);
    end
    check("bounce_valid", kif.key_valid, 0);
    frames(3, 0, 0);

    keys = 16'(1) << 3; frames(4, 0, 0);
    keys = '0;          frames(4, 0, 0);
    keys = 16'(1) << 7; frames(4, 0, 0);
    check("ovr_code", kif.key_code, 3);
    check("ovr_flag", kif.overrun, 1);
    frames(1, 1, 0);
    check("ovr_ack_valid", kif.key_valid, 0);
    check("ovr_ack_flag", kif.overrun, 0);
    keys = '0; frames(4, 0, 0);

    keys = 16'h0021; frames(4, 0, 0);
    check("multi_valid", kif.key_valid, 0);
    keys = 16'h0001; frames(3, 0, 0);
    check("k0_valid", kif.key_valid, 1);
    check("k0_code", kif.key_code, 0);
    keys = '0; frames(4, 1, 0);

    keys = 16'(1) << 12; frames(2, 0, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    keys = '0;
    rst = 1'b1;
    frames(4, 0, 0);
    check("rst_mid_valid", kif.key_valid, 0);
    check("rst_mid_down", kif.key_down, 0);

`ifdef KEYPAD_REPEAT_EN
    keys = 16'(1) << 15; frames(12, 0, 1);
    keys = '0; frames(4, 1, 0);
`endif

    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 19);
      a   = $urandom_range(0, 15);
      b   = $urandom_range(0, 15);
      if (sel < 10)      keys = '0;
      else if (sel < 17) keys = 16'(1) << a;
      else               keys = (16'(1) << a) | (16'(1) << b);
      frames($urandom_range(1, 5), 1'($urandom_range(0, 1)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
